// File: rtl/player_lane_animator_pkg.sv
// Constants and types shared by the keyboard stage, the lane animator and the sprite renderer.
// Lane geometry, game-state encodings, the lane-motion FSM encoding and a lane-legality helper.
package player_lane_animator_pkg;

    localparam logic [2:0] ST_TITLE = 3'b000;
    localparam logic [2:0] ST_PLAY  = 3'b001;

    localparam int X_W        = 10;
    localparam int LANE_PITCH = 136;
    localparam int X_MAX      = 4 * LANE_PITCH;
    localparam int STEP_PX    = 8;

    // One guard bit above the screen coordinate so step arithmetic cannot wrap.
    localparam logic [X_W:0] STEP_W = STEP_PX[X_W:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_R = 2'd1,
        MOVE_L = 2'd2
    } mv_state_e;

    function automatic logic is_lane_x(input logic [X_W-1:0] x);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k * LANE_PITCH <= X_MAX; k++) begin
            if (int'(x) == k * LANE_PITCH) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/player_lane_animator_if.sv
// Lane request in, sprite position/status out; purely level signals with no handshake.
// The master side is the game controller/bench, the slave side is the animator.
interface player_lane_animator_if;
    import player_lane_animator_pkg::*;

    logic [X_W-1:0] target_x;
    logic [2:0]     state;
    logic [X_W-1:0] pos_x;
    logic           moving;
    logic           facing;
    logic [1:0]     walk_frame;
    logic           arrive;

    modport master (
        output target_x, state,
        input  pos_x, moving, facing, walk_frame, arrive
    );

    modport slave (
        input  target_x, state,
        output pos_x, moving, facing, walk_frame, arrive
    );

endinterface

// File: rtl/player_lane_animator_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles; clr zeroes it, !en holds it.
// Tick is combinational from the count register; no backpressure.
module player_lane_animator_tick_divider #(
    parameter int TICK_DIV = 1_666_667
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/player_lane_animator.sv
// Slides the player sprite toward the latched lane at STEP_PX per motion tick; drives facing/walk/arrive.
// Target latched 1 cycle after it appears, motion on the next tick; outputs are registered, no backpressure.
module player_lane_animator
    import player_lane_animator_pkg::*;
#(
    parameter int TICK_DIV = 1_666_667,
    parameter int ANIM_DIV = 4
) (
    input logic                   clk,
    input logic                   rst,
    player_lane_animator_if.slave bus
);
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

    logic in_title;
    logic in_play;
    logic tick;

    assign in_title = (bus.state == ST_TITLE);
    assign in_play  = (bus.state == ST_PLAY);

    player_lane_animator_tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (in_play),
        .clr (in_title),
        .tick(tick)
    );

    mv_state_e      fsm_q, fsm_d;
    logic [X_W-1:0] pos_q, pos_d;
    logic [X_W-1:0] tgt_q, tgt_d;
    logic           facing_q, facing_d;
    logic           arrive_q, arrive_d;
    logic [1:0]     frame_q, frame_d;
    logic [AW-1:0]  anim_q, anim_d;

    logic [X_W:0] pos_w;
    logic [X_W:0] tgt_w;
    logic [X_W:0] up_w;

    assign pos_w = {1'b0, pos_q};
    assign tgt_w = {1'b0, tgt_q};
    assign up_w  = pos_w + STEP_W;

    always_comb begin
        fsm_d    = fsm_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        facing_d = facing_q;
        arrive_d = 1'b0;
        frame_d  = frame_q;
        anim_d   = anim_q;

        if (in_title) begin
            fsm_d    = IDLE;
            pos_d    = '0;
            tgt_d    = '0;
            facing_d = 1'b1;
            frame_d  = '0;
            anim_d   = '0;
        end else if (in_play) begin
            if (is_lane_x(bus.target_x)) tgt_d = bus.target_x;

            // Direction comes straight from the current target so a retarget reverses on the very next tick.
            if (tgt_q > pos_q)      fsm_d = MOVE_R;
            else if (tgt_q < pos_q) fsm_d = MOVE_L;
            else                    fsm_d = IDLE;

            unique case (fsm_d)
                MOVE_R: begin
                    facing_d = 1'b1;
                    if (tick) begin
                        if (up_w >= tgt_w) pos_d = tgt_q;
                        else               pos_d = up_w[X_W-1:0];
                    end
                end
                MOVE_L: begin
                    facing_d = 1'b0;
                    if (tick) begin
                        if (pos_w < tgt_w + STEP_W) pos_d = tgt_q;
                        else                        pos_d = pos_q - STEP_W[X_W-1:0];
                    end
                end
                default: begin
                    frame_d = '0;
                    anim_d  = '0;
                end
            endcase

            if (fsm_d != IDLE && tick) begin
                arrive_d = (pos_d == tgt_q);
                if (anim_q == ANIM_LAST) begin
                    anim_d  = '0;
                    frame_d = frame_q + 2'd1;
                end else begin
                    anim_d = anim_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            pos_q    <= '0;
            tgt_q    <= '0;
            facing_q <= 1'b1;
            arrive_q <= 1'b0;
            frame_q  <= '0;
            anim_q   <= '0;
        end else begin
            fsm_q    <= fsm_d;
            pos_q    <= pos_d;
            tgt_q    <= tgt_d;
            facing_q <= facing_d;
            arrive_q <= arrive_d;
            frame_q  <= frame_d;
            anim_q   <= anim_d;
        end
    end

    assign bus.pos_x      = pos_q;
    assign bus.moving     = (pos_q != tgt_q);
    assign bus.facing     = facing_q;
    assign bus.walk_frame = frame_q;
    assign bus.arrive     = arrive_q;

endmodule

// File: tb/tb_player_lane_animator.sv
// Bench for the lane animator with a fast tick (4 clk) and walk divider of 2.
module tb_player_lane_animator;

    localparam int TD    = 4;
    localparam int AD    = 2;
    localparam int STEP  = 8;
    localparam int PITCH = 136;
    localparam int XMAX  = 544;

    logic clk;
    logic rst;

    player_lane_animator_if bus ();

    player_lane_animator #(
        .TICK_DIV(TD),
        .ANIM_DIV(AD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: position, target, count of play cycles since title/reset, ticks spent moving.
    typedef struct {
        int pos;
        int tgt;
        int pcnt;
        int mticks;
        bit facing;
        bit arrive;
    } mdl_t;

    localparam mdl_t MDL_RST = '{0, 0, 0, 0, 1'b1, 1'b0};

    function automatic mdl_t model_next(input mdl_t m, input int st, input int tx);
        mdl_t n;
        bit   tk;
        n = m;
        n.arrive = 1'b0;
        if (st == 0) begin
            n = MDL_RST;
        end else if (st == 1) begin
            n.pcnt = m.pcnt + 1;
            tk = ((n.pcnt % TD) == 0);
            if (tx <= XMAX && (tx % PITCH) == 0) n.tgt = tx;
            if (m.tgt == m.pos) begin
                n.mticks = 0;
            end else begin
                n.facing = (m.tgt > m.pos);
                if (tk) begin
                    n.mticks = m.mticks + 1;
                    if (m.tgt > m.pos) n.pos = (m.pos + STEP < m.tgt) ? m.pos + STEP : m.tgt;
                    else               n.pos = (m.pos - STEP > m.tgt) ? m.pos - STEP : m.tgt;
                    n.arrive = (n.pos == m.tgt);
                end
            end
        end
        return n;
    endfunction

    mdl_t m = MDL_RST;

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= MDL_RST;
        else      m <= model_next(m, int'(bus.state), int'(bus.target_x));
    end

    task automatic check_model();
        chk("rnd_pos",    bus.pos_x,      m.pos);
        chk("rnd_moving", bus.moving,     (m.pos != m.tgt) ? 1 : 0);
        chk("rnd_facing", bus.facing,     m.facing);
        chk("rnd_frame",  bus.walk_frame, (m.mticks / AD) % 4);
        chk("rnd_arrive", bus.arrive,     m.arrive);
    endtask

    typedef struct {
        int st;
        int tx;
        int cyc;
        int pos;
        int mov;
        int fac;
        int frm;
        int arr;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    int cnt, hit, prev, changes, arrs, r, hold;

    initial begin
        // Directed lane move 0 -> 136, rejected targets at rest, pause, title clear.
        vt[0]  = '{1, 136,  1,   0, 1, 1, 0, 0};
        vt[1]  = '{1, 136,  3,   8, 1, 1, 0, 0};
        vt[2]  = '{1, 136,  4,  16, 1, 1, 1, 0};
        vt[3]  = '{1, 136,  8,  32, 1, 1, 2, 0};
        vt[4]  = '{1, 136, 52, 136, 0, 1, 0, 1};
        vt[5]  = '{1, 136,  1, 136, 0, 1, 0, 0};
        vt[6]  = '{1, 100,  8, 136, 0, 1, 0, 0};
        vt[7]  = '{1, 600,  8, 136, 0, 1, 0, 0};
        vt[8]  = '{1, 680,  8, 136, 0, 1, 0, 0};
        vt[9]  = '{2, 272, 20, 136, 0, 1, 0, 0};
        vt[10] = '{1, 272,  1, 136, 1, 1, 0, 0};
        vt[11] = '{0, 272,  1,   0, 0, 1, 0, 0};

        rst = 1'b0;
        bus.state = 3'd0;
        bus.target_x = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pos",    bus.pos_x,      0);
        chk("rst_moving", bus.moving,     0);
        chk("rst_facing", bus.facing,     1);
        chk("rst_frame",  bus.walk_frame, 0);
        chk("rst_arrive", bus.arrive,     0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.state    = 3'(vt[i].st);
            bus.target_x = 10'(vt[i].tx);
            repeat (vt[i].cyc) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_pos", i),    bus.pos_x,      vt[i].pos);
            chk($sformatf("vec%0d_moving", i), bus.moving,     vt[i].mov);
            chk($sformatf("vec%0d_facing", i), bus.facing,     vt[i].fac);
            chk($sformatf("vec%0d_frame", i),  bus.walk_frame, vt[i].frm);
            chk($sformatf("vec%0d_arrive", i), bus.arrive,     vt[i].arr);
        end

        // Reverse mid-move: 0 -> 136, retarget to 0 at pos 40.
        bus.state = 3'd1;
        bus.target_x = 10'd136;
        cnt = 0;
        hit = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            @(negedge clk);
            cnt++;
            if (bus.pos_x == 10'd40) hit = 1;
        end
        chk("rev_reach40_cycles", cnt, 20);
        bus.target_x = 10'd0;
        repeat (2) @(negedge clk);
        chk("rev_facing_left", bus.facing, 0);
        prev = 40;
        changes = 0;
        arrs = 0;
        hit = 0;
        for (int c = 0; c < 100 && hit == 0; c++) begin
            @(negedge clk);
            if (int'(bus.pos_x) != prev) changes++;
            prev = int'(bus.pos_x);
            if (bus.arrive) arrs++;
            if (bus.pos_x == 10'd0) hit = 1;
        end
        @(negedge clk);
        if (bus.arrive) arrs++;
        chk("rev_reached0", hit, 1);
        chk("rev_tick_steps", changes, 5);
        chk("rev_arrive_count", arrs, 1);
        chk("rev_idle_moving", bus.moving, 0);

        // Pause mid-move to 408: position and tick phase must freeze.
        bus.state = 3'd0;
        @(negedge clk);
        bus.state = 3'd1;
        bus.target_x = 10'd408;
        repeat (30) @(negedge clk);
        chk("pause_entry_pos", bus.pos_x, 56);
        prev = int'(bus.pos_x);
        bus.state = 3'd2;
        repeat (20) @(negedge clk);
        chk("pause_hold_pos", bus.pos_x, prev);
        chk("pause_arrive", bus.arrive, 0);
        bus.state = 3'd1;
        cnt = 30;
        hit = 0;
        for (int c = 0; c < 400 && hit == 0; c++) begin
            @(negedge clk);
            cnt++;
            if (!bus.moving) hit = 1;
        end
        chk("pause_total_play_cycles", cnt, 204);
        chk("pause_final_pos", bus.pos_x, 408);

        // Async reset mid-move at pos 200, then title mid-move.
        bus.state = 3'd0;
        @(negedge clk);
        bus.state = 3'd1;
        bus.target_x = 10'd272;
        cnt = 0;
        hit = 0;
        for (int c = 0; c < 300 && hit == 0; c++) begin
            @(negedge clk);
            cnt++;
            if (bus.pos_x == 10'd200) hit = 1;
        end
        chk("arst_reach200_cycles", cnt, 100);
        #2 rst = 1'b0;
        #1;
        chk("arst_pos",    bus.pos_x,      0);
        chk("arst_moving", bus.moving,     0);
        chk("arst_facing", bus.facing,     1);
        chk("arst_frame",  bus.walk_frame, 0);
        chk("arst_arrive", bus.arrive,     0);
        @(negedge clk);
        rst = 1'b1;
        bus.target_x = 10'd136;
        repeat (20) @(negedge clk);
        chk("title_pre_pos", bus.pos_x, 40);
        chk("title_pre_moving", bus.moving, 1);
        bus.state = 3'd0;
        @(negedge clk);
        chk("title_pos", bus.pos_x, 0);
        chk("title_moving", bus.moving, 0);
        chk("title_facing", bus.facing, 1);

        // Randomized play/pause/title with legal and illegal targets against the reference.
        for (int s = 0; s < 250; s++) begin
            r = int'($urandom_range(0, 19));
            if (r < 15)       bus.state = 3'd1;
            else if (r < 18)  bus.state = 3'(2 + $urandom_range(0, 5));
            else              bus.state = 3'd0;
            if ($urandom_range(0, 9) < 7) bus.target_x = 10'($urandom_range(0, 4) * PITCH);
            else                          bus.target_x = 10'($urandom_range(0, 1023));
            hold = int'($urandom_range(1, 40));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check_model();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
